// File: rtl/scarv_soc_bram_arbiter_pkg.sv
// rtl/scarv_soc_bram_arbiter_pkg.sv - shared encodings for the BRAM arbiter
//
// Purpose : Response-slot state encoding and memory-bus response codes shared
//           by the arbiter top and its response slots.
// Ports   : none (package).
package scarv_soc_bram_arbiter_pkg;

   typedef enum logic [1:0] {
      SLOT_IDLE  = 2'd0,
      SLOT_FIRST = 2'd1,
      SLOT_HOLD  = 2'd2
   } slot_state_t;

   localparam logic MEM_RSP_OK  = 1'b0;
   localparam logic MEM_RSP_ERR = 1'b1;

endpackage

// File: rtl/scarv_soc_bram_rsp_slot.sv
// rtl/scarv_soc_bram_rsp_slot.sv - one-deep response slot for a BRAM requester
//
// Purpose : Tracks one outstanding response. In FIRST the read data flows
//           straight from the BRAM output; if the requester stalls, the
//           response is captured into a hold register so the BRAM port can
//           serve the other requester meanwhile.
// Ports   : g_clk/g_resetn  clock, async active-low reset
//           accept          request from this requester accepted this cycle
//           rd_pass         accepted request is an in-range read
//           rsp_code        response code of the accepted request
//           ack             requester accepts the current response
//           bram_dout       registered BRAM read data
//           free            slot can take a new request this cycle
//           recv/error/rdata response to the requester
module scarv_soc_bram_rsp_slot
   import scarv_soc_bram_arbiter_pkg::*;
(
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        accept,
   input  logic        rd_pass,
   input  logic        rsp_code,
   input  logic        ack,
   input  logic [31:0] bram_dout,
   output logic        free,
   output logic        recv,
   output logic        error,
   output logic [31:0] rdata
);

   slot_state_t state;
   slot_state_t state_nxt;
   logic        pend_rd;
   logic        pend_err;
   logic        hold_err;
   logic [31:0] hold_rdata;

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) state <= SLOT_IDLE;
      else           state <= state_nxt;
   end

   // FIRST with ack and a fresh accept stays in FIRST: back-to-back service.
   always_comb begin
      state_nxt = state;
      case (state)
         SLOT_IDLE:  if (accept) state_nxt = SLOT_FIRST;
         SLOT_FIRST: begin
            if (!ack)         state_nxt = SLOT_HOLD;
            else if (!accept) state_nxt = SLOT_IDLE;
         end
         SLOT_HOLD:  if (ack) state_nxt = accept ? SLOT_FIRST : SLOT_IDLE;
         default:    state_nxt = SLOT_IDLE;
      endcase
   end

   always_comb begin
      recv  = 1'b0;
      error = 1'b0;
      rdata = '0;
      case (state)
         SLOT_FIRST: begin
            recv  = 1'b1;
            error = pend_err;
            rdata = pend_rd ? bram_dout : '0;
         end
         SLOT_HOLD: begin
            recv  = 1'b1;
            error = hold_err;
            rdata = hold_rdata;
         end
         default: ;
      endcase
   end

   // Depends only on state and ack, so gnt never sees bram_dout.
   assign free = !recv || ack;

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         pend_rd    <= 1'b0;
         pend_err   <= 1'b0;
         hold_err   <= 1'b0;
         hold_rdata <= '0;
      end else begin
         if (accept) begin
            pend_rd  <= rd_pass;
            pend_err <= (rsp_code == MEM_RSP_ERR);
         end
         if (state == SLOT_FIRST && !ack) begin
            hold_rdata <= rdata;
            hold_err   <= error;
         end
      end
   end

endmodule

// File: rtl/scarv_soc_bram_arbiter.sv
// rtl/scarv_soc_bram_arbiter.sv - two-requester round-robin BRAM port arbiter
//
// Purpose : Shares one BRAM port between two memory-bus requesters with
//           round-robin priority, range-checks addresses and returns one
//           response per accepted request with backpressure.
// Ports   : g_clk/g_resetn            clock, async active-low reset
//           rx_req/gnt/wen/strb/addr/wdata  request channel of requester x
//           rx_recv/ack/error/rdata   response channel of requester x
//           bram_en/we/addr/din       BRAM port drive
//           bram_dout                 BRAM read data (one-cycle latency)
module scarv_soc_bram_arbiter
   import scarv_soc_bram_arbiter_pkg::*;
#(
   parameter int          DEPTH    = 1024,
   parameter logic [31:0] BASE     = 32'h0000_0000,
   parameter bit          WRITE_EN = 1'b1,
   localparam int         LW       = $clog2(DEPTH)
)(
   input  logic          g_clk,
   input  logic          g_resetn,
   input  logic          r0_req,
   output logic          r0_gnt,
   input  logic          r0_wen,
   input  logic [3:0]    r0_strb,
   input  logic [31:0]   r0_addr,
   input  logic [31:0]   r0_wdata,
   output logic          r0_recv,
   input  logic          r0_ack,
   output logic          r0_error,
   output logic [31:0]   r0_rdata,
   input  logic          r1_req,
   output logic          r1_gnt,
   input  logic          r1_wen,
   input  logic [3:0]    r1_strb,
   input  logic [31:0]   r1_addr,
   input  logic [31:0]   r1_wdata,
   output logic          r1_recv,
   input  logic          r1_ack,
   output logic          r1_error,
   output logic [31:0]   r1_rdata,
   output logic          bram_en,
   output logic [3:0]    bram_we,
   output logic [LW-1:0] bram_addr,
   output logic [31:0]   bram_din,
   input  logic [31:0]   bram_dout
);

   logic        free0, free1;
   logic        elig0, elig1;
   logic        last;
   logic        sel;
   logic        accept;
   logic        wen;
   logic [3:0]  strb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        in_range;
   logic        bad;
   logic        rsp;

   // Gating with g_resetn keeps gnt and the BRAM drive at 0 during reset.
   assign elig0 = g_resetn & r0_req & free0;
   assign elig1 = g_resetn & r1_req & free1;

   // last=1 means r1 was granted most recently, so r0 wins a tie.
   assign r0_gnt = elig0 & (~elig1 | last);
   assign r1_gnt = elig1 & (~elig0 | ~last);
   assign accept = r0_gnt | r1_gnt;
   assign sel    = r1_gnt;

   assign wen   = sel ? r1_wen   : r0_wen;
   assign strb  = sel ? r1_strb  : r0_strb;
   assign addr  = sel ? r1_addr  : r0_addr;
   assign wdata = sel ? r1_wdata : r0_wdata;

   // BASE is DEPTH-aligned, so the window test is an upper-bit match.
   assign in_range = (addr[31:LW] == BASE[31:LW]);
   assign bad      = ~in_range | (wen & ~WRITE_EN);
   assign rsp      = bad ? MEM_RSP_ERR : MEM_RSP_OK;

   assign bram_en   = accept & ~bad;
   assign bram_addr = bram_en ? addr[LW-1:0] : '0;
   assign bram_din  = bram_en ? wdata : '0;
   assign bram_we   = (bram_en & wen & WRITE_EN) ? strb : 4'b0;

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn)   last <= 1'b1;
      else if (accept) last <= sel;
   end

   scarv_soc_bram_rsp_slot u_slot0 (
      .g_clk     (g_clk),
      .g_resetn  (g_resetn),
      .accept    (r0_gnt),
      .rd_pass   (~wen & ~bad),
      .rsp_code  (rsp),
      .ack       (r0_ack),
      .bram_dout (bram_dout),
      .free      (free0),
      .recv      (r0_recv),
      .error     (r0_error),
      .rdata     (r0_rdata)
   );

   scarv_soc_bram_rsp_slot u_slot1 (
      .g_clk     (g_clk),
      .g_resetn  (g_resetn),
      .accept    (r1_gnt),
      .rd_pass   (~wen & ~bad),
      .rsp_code  (rsp),
      .ack       (r1_ack),
      .bram_dout (bram_dout),
      .free      (free1),
      .recv      (r1_recv),
      .error     (r1_error),
      .rdata     (r1_rdata)
   );

endmodule

// File: tb/tb_scarv_soc_bram_arbiter.sv
// tb/tb_scarv_soc_bram_arbiter.sv - self-checking bench for the BRAM arbiter
module tb_scarv_soc_bram_arbiter;

   localparam int LW = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          r0_req, r0_wen, r0_ack, r1_req, r1_wen, r1_ack;
   logic [3:0]    r0_strb, r1_strb;
   logic [31:0]   r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic          r0_gnt, r0_recv, r0_error, r1_gnt, r1_recv, r1_error;
   logic [31:0]   r0_rdata, r1_rdata;
   logic          bram_en;
   logic [3:0]    bram_we;
   logic [LW-1:0] bram_addr;
   logic [31:0]   bram_din;
   logic [31:0]   bram_dout = '0;

   logic          rom_req, rom_wen, rom_ack;
   logic [3:0]    rom_strb;
   logic [31:0]   rom_addr, rom_wdata;
   logic          rom_gnt, rom_recv, rom_error, rom1_gnt, rom1_recv, rom1_error;
   logic [31:0]   rom_rdata, rom1_rdata;
   logic          rom_en;
   logic [3:0]    rom_we;
   logic [LW-1:0] rom_baddr;
   logic [31:0]   rom_din;

   scarv_soc_bram_arbiter #(.DEPTH(1024), .BASE(32'h0), .WRITE_EN(1'b1)) dut (
      .g_clk(clk), .g_resetn(rst_n),
      .r0_req(r0_req), .r0_gnt(r0_gnt), .r0_wen(r0_wen), .r0_strb(r0_strb),
      .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_recv(r0_recv), .r0_ack(r0_ack),
      .r0_error(r0_error), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_gnt(r1_gnt), .r1_wen(r1_wen), .r1_strb(r1_strb),
      .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_recv(r1_recv), .r1_ack(r1_ack),
      .r1_error(r1_error), .r1_rdata(r1_rdata),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_din(bram_din), .bram_dout(bram_dout)
   );

   scarv_soc_bram_arbiter #(.DEPTH(1024), .BASE(32'h0), .WRITE_EN(1'b0)) dut_rom (
      .g_clk(clk), .g_resetn(rst_n),
      .r0_req(rom_req), .r0_gnt(rom_gnt), .r0_wen(rom_wen), .r0_strb(rom_strb),
      .r0_addr(rom_addr), .r0_wdata(rom_wdata), .r0_recv(rom_recv), .r0_ack(rom_ack),
      .r0_error(rom_error), .r0_rdata(rom_rdata),
      .r1_req(1'b0), .r1_gnt(rom1_gnt), .r1_wen(1'b0), .r1_strb(4'h0),
      .r1_addr(32'h0), .r1_wdata(32'h0), .r1_recv(rom1_recv), .r1_ack(1'b1),
      .r1_error(rom1_error), .r1_rdata(rom1_rdata),
      .bram_en(rom_en), .bram_we(rom_we), .bram_addr(rom_baddr),
      .bram_din(rom_din), .bram_dout(32'h5A5A_1234)
   );

   // Behavioural BRAM: registered read-first port plus a bench preload port.
   logic [31:0] mem [0:255];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_idx;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      else if (bram_en) begin
         bram_dout <= mem[bram_addr[9:2]];
         for (int b = 0; b < 4; b++)
            if (bram_we[b]) mem[bram_addr[9:2]][8*b +: 8] <= bram_din[8*b +: 8];
      end
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic idle_all();
      r0_req = 0; r0_wen = 0; r0_strb = 0; r0_addr = 0; r0_wdata = 0; r0_ack = 1;
      r1_req = 0; r1_wen = 0; r1_strb = 0; r1_addr = 0; r1_wdata = 0; r1_ack = 1;
      rom_req = 0; rom_wen = 0; rom_strb = 0; rom_addr = 0; rom_wdata = 0; rom_ack = 1;
   endtask

   task automatic set_req(input logic id, input logic wen, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata);
      if (id) begin r1_req = 1; r1_wen = wen; r1_strb = strb; r1_addr = addr; r1_wdata = wdata; end
      else    begin r0_req = 1; r0_wen = wen; r0_strb = strb; r0_addr = addr; r0_wdata = wdata; end
   endtask

   typedef struct {
      logic        id;
      logic        wen;
      logic [3:0]  strb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        en;
      logic [3:0]  we;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs [7];

   // Reference model state for the randomized phase.
   logic [31:0] refmem [0:7];
   logic        qv [2];
   logic [31:0] qd [2];
   logic        qe [2];
   logic        rq [2], rw [2], ak [2];
   logic [3:0]  rs [2];
   logic [31:0] ra [2], rd [2];
   logic        elig [2];
   logic        oor;
   logic        exp_en;
   int          last_win, win, r;

   initial begin
      vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,          1'b1, 4'h0, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD, 1'b1, 4'b0101, 32'h0,    1'b0};
      vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0,          1'b1, 4'h0, 32'h11BB_33DD, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0400, 32'h0,          1'b0, 4'h0, 32'h0,         1'b1};
      vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0000_03FC, 32'h0,          1'b1, 4'h0, 32'hCAFE_F00D, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h0000_0001,  1'b0, 4'h0, 32'h0,         1'b1};
      vecs[6] = '{1'b0, 1'b0, 4'h0, 32'h0000_03FE, 32'h0,          1'b1, 4'h0, 32'hCAFE_F00D, 1'b0};

      idle_all();
      // Preload while in reset.
      @(negedge clk); pl_en = 1; pl_idx = 8'd4;   pl_data = 32'hDEAD_BEEF;
      @(negedge clk);            pl_idx = 8'd8;   pl_data = 32'h1122_3344;
      @(negedge clk);            pl_idx = 8'd255; pl_data = 32'hCAFE_F00D;
      @(negedge clk); pl_en = 0;
      r0_req = 1; r1_req = 1;
      #1;
      chk("reset r0_gnt", r0_gnt, 0);
      chk("reset r1_gnt", r1_gnt, 0);
      chk("reset r0_recv", r0_recv, 0);
      chk("reset bram_en", bram_en, 0);
      chk("reset r0_rdata", r0_rdata, 0);
      @(negedge clk); idle_all(); rst_n = 1;

      // Contention right after reset: r0 first, then alternate.
      @(negedge clk);
      set_req(0, 0, 0, 32'h10, 0);
      set_req(1, 0, 0, 32'h20, 0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         chk($sformatf("contend%0d r0_gnt", i), r0_gnt, (i % 2 == 0));
         chk($sformatf("contend%0d r1_gnt", i), r1_gnt, (i % 2 == 1));
         chk($sformatf("contend%0d bram_en", i), bram_en, 1);
      end
      @(negedge clk); idle_all();
      @(negedge clk);

      // Single transactions with ack tied high.
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); idle_all();
         set_req(vecs[i].id, vecs[i].wen, vecs[i].strb, vecs[i].addr, vecs[i].wdata);
         #1;
         chk($sformatf("vec%0d gnt", i), vecs[i].id ? r1_gnt : r0_gnt, 1);
         chk($sformatf("vec%0d bram_en", i), bram_en, vecs[i].en);
         chk($sformatf("vec%0d bram_we", i), bram_we, vecs[i].we);
         chk($sformatf("vec%0d bram_addr", i), bram_addr,
             vecs[i].en ? {22'b0, vecs[i].addr[9:0]} : 32'h0);
         chk($sformatf("vec%0d bram_din", i), bram_din, vecs[i].en ? vecs[i].wdata : 32'h0);
         @(negedge clk); idle_all(); #1;
         chk($sformatf("vec%0d recv", i),  vecs[i].id ? r1_recv  : r0_recv, 1);
         chk($sformatf("vec%0d rdata", i), vecs[i].id ? r1_rdata : r0_rdata, vecs[i].rdata);
         chk($sformatf("vec%0d error", i), vecs[i].id ? r1_error : r0_error, vecs[i].err);
      end

      // Backpressure: r0 stalls its response while r1 keeps being served.
      @(negedge clk); idle_all();
      set_req(0, 0, 0, 32'h10, 0); r0_ack = 0;
      #1; chk("bp0 r0_gnt", r0_gnt, 1);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         set_req(1, 0, 0, 32'h20, 0);
         #1;
         chk($sformatf("bp%0d r0_gnt", i), r0_gnt, 0);
         chk($sformatf("bp%0d r1_gnt", i), r1_gnt, 1);
         chk($sformatf("bp%0d r0_recv", i), r0_recv, 1);
         chk($sformatf("bp%0d r0_rdata", i), r0_rdata, 32'hDEAD_BEEF);
         if (i > 1) chk($sformatf("bp%0d r1_rdata", i), r1_rdata, 32'h11BB_33DD);
      end
      @(negedge clk); r0_ack = 1; r1_req = 0; #1;
      chk("bp4 r0_gnt", r0_gnt, 1);
      chk("bp4 r0_rdata", r0_rdata, 32'hDEAD_BEEF);
      chk("bp4 r1_recv", r1_recv, 1);
      @(negedge clk); idle_all(); #1;
      chk("bp5 r0_recv", r0_recv, 1);
      chk("bp5 r0_rdata", r0_rdata, 32'hDEAD_BEEF);
      chk("bp5 r1_recv", r1_recv, 0);

      // ROM instance: write is an error, read passes through.
      @(negedge clk); idle_all();
      rom_req = 1; rom_wen = 1; rom_strb = 4'hF; rom_addr = 32'h10; rom_wdata = 32'h1234_5678;
      #1;
      chk("rom wr gnt", rom_gnt, 1);
      chk("rom wr bram_en", rom_en, 0);
      chk("rom wr bram_we", rom_we, 0);
      chk("rom wr bram_din", rom_din, 0);
      @(negedge clk); rom_wen = 0; #1;
      chk("rom wr recv", rom_recv, 1);
      chk("rom wr error", rom_error, 1);
      chk("rom wr rdata", rom_rdata, 0);
      chk("rom rd gnt", rom_gnt, 1);
      chk("rom rd bram_en", rom_en, 1);
      chk("rom rd bram_addr", rom_baddr, 32'h10);
      @(negedge clk); idle_all(); #1;
      chk("rom rd error", rom_error, 0);
      chk("rom rd rdata", rom_rdata, 32'h5A5A_1234);
      chk("rom r1 idle", {rom1_gnt, rom1_recv, rom1_error}, 0);
      chk("rom r1 rdata", rom1_rdata, 0);

      // Reset while r0 sits in HOLD and r1 was granted last.
      @(negedge clk); idle_all();
      set_req(0, 0, 0, 32'h10, 0); r0_ack = 0;
      #1; chk("rst r0_gnt", r0_gnt, 1);
      @(negedge clk); r0_req = 0; set_req(1, 0, 0, 32'h20, 0);
      #1; chk("rst r1_gnt", r1_gnt, 1);
      @(negedge clk); r1_req = 0; r0_req = 1;
      #1;
      chk("rst hold recv", r0_recv, 1);
      chk("rst hold gnt", r0_gnt, 0);
      r1_req = 1; rst_n = 0;
      #1;
      chk("rst async recv", r0_recv, 0);
      chk("rst async rdata", r0_rdata, 0);
      chk("rst async gnt", {r0_gnt, r1_gnt}, 0);
      chk("rst async bram_en", bram_en, 0);
      @(negedge clk); rst_n = 1; r0_ack = 1;
      #1;
      chk("rst after r0_gnt", r0_gnt, 1);
      chk("rst after r1_gnt", r1_gnt, 0);

      // Randomized phase against the reference model.
      @(negedge clk); idle_all(); rst_n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); pl_en = 1; pl_idx = 8'(i); pl_data = $urandom; refmem[i] = pl_data;
      end
      @(negedge clk); pl_en = 0; rst_n = 1;
      last_win = 1;
      for (int x = 0; x < 2; x++) begin qv[x] = 0; qd[x] = 0; qe[x] = 0; end

      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         for (int x = 0; x < 2; x++) begin
            rq[x] = ($urandom_range(3) != 0);
            rw[x] = 1'($urandom_range(1));
            rs[x] = 4'($urandom_range(15));
            r = int'($urandom_range(9));
            if (r < 8)       ra[x] = 32'(r * 4) + 32'($urandom_range(3));
            else if (r == 8) ra[x] = 32'h400 + 32'($urandom_range(255) * 4);
            else             ra[x] = 32'h8000_0000 | $urandom;
            rd[x] = $urandom;
            ak[x] = ($urandom_range(3) != 0);
         end
         r0_req = rq[0]; r0_wen = rw[0]; r0_strb = rs[0]; r0_addr = ra[0]; r0_wdata = rd[0]; r0_ack = ak[0];
         r1_req = rq[1]; r1_wen = rw[1]; r1_strb = rs[1]; r1_addr = ra[1]; r1_wdata = rd[1]; r1_ack = ak[1];
         #1;
         for (int x = 0; x < 2; x++) elig[x] = rq[x] && (!qv[x] || ak[x]);
         win = -1;
         if (elig[0] && elig[1]) win = 1 - last_win;
         else if (elig[0])       win = 0;
         else if (elig[1])       win = 1;
         exp_en = (win >= 0) && (ra[win] < 32'd1024);

         chk($sformatf("rnd%0d r0_gnt", c), r0_gnt, win == 0);
         chk($sformatf("rnd%0d r1_gnt", c), r1_gnt, win == 1);
         chk($sformatf("rnd%0d bram_en", c), bram_en, exp_en);
         if (exp_en) chk($sformatf("rnd%0d bram_we", c), bram_we, rw[win] ? rs[win] : 4'h0);
         chk($sformatf("rnd%0d r0_recv", c), r0_recv, qv[0]);
         chk($sformatf("rnd%0d r1_recv", c), r1_recv, qv[1]);
         if (qv[0]) chk($sformatf("rnd%0d r0_rsp", c), {r0_error, r0_rdata[30:0]}, {qe[0], qd[0][30:0]});
         if (qv[0]) chk($sformatf("rnd%0d r0_rdata", c), r0_rdata, qd[0]);
         if (qv[1]) chk($sformatf("rnd%0d r1_error", c), r1_error, qe[1]);
         if (qv[1]) chk($sformatf("rnd%0d r1_rdata", c), r1_rdata, qd[1]);

         for (int x = 0; x < 2; x++) if (ak[x] && qv[x]) qv[x] = 0;
         if (win >= 0) begin
            oor = (ra[win] >= 32'd1024);
            qv[win] = 1;
            qe[win] = oor;
            qd[win] = (oor || rw[win]) ? 32'h0 : refmem[ra[win][4:2]];
            if (!oor && rw[win])
               for (int b = 0; b < 4; b++)
                  if (rs[win][b]) refmem[ra[win][4:2]][8*b +: 8] = rd[win][8*b +: 8];
            last_win = win;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
